sram_bridge: RTL and testbench
==============================

# sram_bridge

Parametrised bridge between the CPU's general-purpose I/O bus (request held until a one-cycle ready) and an external asynchronous SRAM. It is the next-generation replacement for the fixed 32-bit inline SRAM state machine in the co-processor tops. It generalises data width, address width and access latency. It adds native byte-lane strobes as an alternative to read-modify-write, latches request fields at acceptance, and optionally posts writes.

## Interface
Parameters:
- DW, 32, data width; multiple of 8, 8..64; lanes NB = DW/8
- AW, 19, SRAM word-address width
- LATENCY, 1, extra wait cycles per SRAM phase, 0..7
- NATIVE_BE, 0, 1 = SRAM has per-lane strobes (partial writes direct); 0 = partial writes by read-modify-write

Ports:
- clk  in  1  sole clock
- rst_b  in  1  asynchronous, active-low reset
- req_rd  in  1  read request, held until rsp_ready
- req_wr  in  1  write request, held until rsp_ready
- req_addr  in  AW  word address
- req_be  in  NB  byte enables, bit i = data[8i+7:8i]
- req_wdata  in  DW  write data
- rsp_rdata  out  DW  read data, valid while rsp_ready
- rsp_ready  out  1  one-cycle completion pulse
- ram_cs_b, ram_oe_b, ram_we_b  out  1 each  active-low SRAM strobes
- ram_be_b  out  NB  active-low lane strobes
- ram_addr  out  AW  SRAM address
- ram_dq_o  out  DW  SRAM write data
- ram_dq_oe  out  1  data-bus drive enable (tri-state lives in top)
- ram_dq_i  in  DW  SRAM read data

## Operation
- States: IDLE, READ, RMW_READ, WRITE. A counter lcount is loaded with LATENCY on phase entry. It decrements each cycle and the phase ends on the edge where it is 0.
- IDLE accepts only when rsp_ready=0. On acceptance, req_addr, req_be and req_wdata are latched; the requester may change them afterwards.
- Priority: req_rd over req_wr. If both are asserted, the read is performed; the write is ignored for that request.
- Read: READ with cs_b=oe_b=0, be_b=0. On phase end, rsp_rdata<=ram_dq_i, strobes deassert, rsp_ready<=1, then IDLE.
- Write, all lanes set, or NATIVE_BE=1: WRITE with cs_b=we_b=0, dq_oe=1, ram_be_b=~be (all 0 when NATIVE_BE=0). On phase end, strobes and dq_oe drop, rsp_ready<=1, then IDLE.
- Partial write with NATIVE_BE=0: RMW_READ, a read with all lanes enabled. On phase end, write data = per-lane mux (be ? wdata : ram_dq_i), then go straight to WRITE.
- Write with be=0: no SRAM cycle; rsp_ready pulses on the edge after acceptance.
- rsp_ready is high for exactly one cycle and is cleared in IDLE. rsp_rdata holds its value until the next read completes.
- Reset (asynchronous, any state): all strobes deassert immediately (cs_b/oe_b/we_b=1, be_b all 1), dq_oe=0, ram_addr=0, ram_dq_o=0, rsp_rdata=0, rsp_ready=0, state IDLE, lcount=0. An in-flight write is abandoned.

## Timing
- E0 is the edge that accepts a request. Strobes assert from E0.
- READ or full WRITE: strobes active LATENCY+1 cycles; rsp_ready rises at E(LATENCY+1).
- RMW: read phase E0..E(L+1), write phase E(L+1)..E(2L+2); rsp_ready rises at E(2L+2).
- ram_addr is stable across both RMW phases.
- ram_dq_o is registered and valid whenever dq_oe=1.

## Configuration
- Macro SRAM_BRIDGE_WRITE_POST_EN.
- Defined: for every write that reaches WRITE or RMW_READ, rsp_ready rises at E0 and the SRAM cycle completes in the background. The next request is held off (not accepted) until the bridge returns to IDLE. Read timing is unchanged.
- Undefined: rsp_ready for a write rises only at completion, as in Timing.

## Structure
- Package sram_bridge_pkg holds:
  - the state enum
  - LATENCY width constant (3 bits)
  - lane-merge function merge_lanes(be, new, old)
- One sub-module is natural: sram_bridge_lane_merge, a combinational per-lane merge used by the RMW path.

## Test plan
Defaults unless stated: DW=32, AW=19, LATENCY=1, NATIVE_BE=0.
- Full write addr 0x00010, data 0xDEADBEEF, be 1111 -> we_b low 2 cycles, dq_o=0xDEADBEEF, rsp_ready at E2. Then a read of 0x00010 -> rsp_rdata=0xDEADBEEF at E2.
- Memory holds 0x11223344; write be 0100, data 0x00AA0000 -> one read phase then one write phase; dq_o=0x11AA3344; rsp_ready at E4.
- NATIVE_BE=1, same partial write -> no read phase, ram_be_b=1011, rsp_ready at E2.
- req_rd=req_wr=1 with addr 0x00020 -> read only, we_b never asserted.
- SRAM_BRIDGE_WRITE_POST_EN defined, full write followed immediately by a read -> write rsp_ready at E0. The read is accepted only after we_b deasserts, and the read's rsp_ready arrives 2 cycles after its acceptance.
- rst_b low mid-WRITE -> cs_b/we_b=1 and dq_oe=0 without waiting for a clock edge; first request after release behaves normally.

Source files
------------

// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the CPU-bus to asynchronous-SRAM bridge.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    RMW_READ = 2'd2,
    WRITE    = 2'd3
  } state_t;

  localparam int LAT_W  = 3;
  localparam int MAX_DW = 64;
  localparam int MAX_NB = MAX_DW / 8;

  // Per-lane select: enabled lanes take new_dat, the rest keep old_dat.
  function automatic logic [MAX_DW-1:0] merge_lanes(
    input logic [MAX_NB-1:0] be,
    input logic [MAX_DW-1:0] new_dat,
    input logic [MAX_DW-1:0] old_dat
  );
    logic [MAX_DW-1:0] m;
    for (int i = 0; i < MAX_NB; i++) begin
      m[8*i +: 8] = be[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_bridge_lane_merge.sv
// Combinational byte-lane merge of new write data over data read back from the SRAM.
import sram_bridge_pkg::*;

module sram_bridge_lane_merge #(
  parameter int DW = 32
) (
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   new_dat,
  input  logic [DW-1:0]   old_dat,
  output logic [DW-1:0]   merged
);

  assign merged = DW'(merge_lanes(MAX_NB'(be), MAX_DW'(new_dat), MAX_DW'(old_dat)));

endmodule

// File: rtl/sram_bridge.sv
// CPU I/O bus to asynchronous SRAM bridge with optional byte-lane strobes or read-modify-write.
// SRAM_BRIDGE_WRITE_POST_EN: acknowledge writes at acceptance and finish the SRAM cycle in the background.
import sram_bridge_pkg::*;

module sram_bridge #(
  parameter int DW        = 32,
  parameter int AW        = 19,
  parameter int LATENCY   = 1,
  parameter bit NATIVE_BE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW/8-1:0]   req_be,
  input  logic [DW-1:0]     req_wdata,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_ready,
  output logic              ram_cs_b,
  output logic              ram_oe_b,
  output logic              ram_we_b,
  output logic [DW/8-1:0]   ram_be_b,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_dq_o,
  output logic              ram_dq_oe,
  input  logic [DW-1:0]     ram_dq_i
);

  localparam int NB = DW / 8;
  localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);
`ifdef SRAM_BRIDGE_WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lcount;
  logic [NB-1:0]    be_q;
  logic [DW-1:0]    merged;
  logic             accept, phase_end;

  assign accept    = (state == IDLE) && !rsp_ready && (req_rd || req_wr);
  assign phase_end = (state != IDLE) && (lcount == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_rd)                      state_nxt = READ;
          else if (req_be == '0)           state_nxt = IDLE;
          else if (NATIVE_BE || (&req_be)) state_nxt = WRITE;
          else                             state_nxt = RMW_READ;
        end
      end
      READ:     if (phase_end) state_nxt = IDLE;
      RMW_READ: if (phase_end) state_nxt = WRITE;
      WRITE:    if (phase_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset releases them without a clock.
  always_comb begin
    ram_cs_b  = 1'b1;
    ram_oe_b  = 1'b1;
    ram_we_b  = 1'b1;
    ram_be_b  = '1;
    ram_dq_oe = 1'b0;
    case (state)
      READ, RMW_READ: begin
        ram_cs_b = 1'b0;
        ram_oe_b = 1'b0;
        ram_be_b = '0;
      end
      WRITE: begin
        ram_cs_b  = 1'b0;
        ram_we_b  = 1'b0;
        ram_dq_oe = 1'b1;
        ram_be_b  = NATIVE_BE ? ~be_q : '0;
      end
      default: ;
    endcase
  end

  sram_bridge_lane_merge #(.DW(DW)) u_merge (
    .be      (be_q),
    .new_dat (ram_dq_o),
    .old_dat (ram_dq_i),
    .merged  (merged)
  );

  // ram_dq_o doubles as the write-data latch until the RMW merge overwrites it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lcount    <= '0;
      be_q      <= '0;
      ram_addr  <= '0;
      ram_dq_o  <= '0;
      rsp_rdata <= '0;
      rsp_ready <= 1'b0;
    end else begin
      rsp_ready <= 1'b0;
      if (accept) begin
        lcount   <= LAT;
        ram_addr <= req_addr;
        be_q     <= req_be;
        if (!req_rd) begin
          ram_dq_o <= req_wdata;
          if ((req_be == '0) || POST) rsp_ready <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (lcount != '0) begin
          lcount <= lcount - LAT_W'(1);
        end else begin
          case (state)
            READ: begin
              rsp_rdata <= ram_dq_i;
              rsp_ready <= 1'b1;
            end
            RMW_READ: begin
              ram_dq_o <= merged;
              lcount   <= LAT;
            end
            WRITE:   rsp_ready <= !POST;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Randomized bench for sram_bridge against an edge-accurate transaction model and an SRAM model.
module tb_sram_bridge;

  localparam int L = 1;
`ifdef SRAM_BRIDGE_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [18:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rsp_rdata, ram_dq_o, ram_dq_i;
  logic        rsp_ready, ram_cs_b, ram_oe_b, ram_we_b, ram_dq_oe;
  logic [3:0]  ram_be_b;
  logic [18:0] ram_addr;

  logic        nb_rd = 1'b0, nb_wr = 1'b0;
  logic [31:0] nb_rdata, nb_dq_o;
  logic [31:0] nb_dq_i = 32'h1122_3344;
  logic        nb_ready, nb_cs_b, nb_oe_b, nb_we_b, nb_dq_oe;
  logic [3:0]  nb_be_b;
  logic [18:0] nb_addr;

  always #5 clk = ~clk;

  sram_bridge #(.DW(32), .AW(19), .LATENCY(L), .NATIVE_BE(1'b0)) u_dut (
    .clk(clk), .rst_b(rst_b), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
    .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b), .ram_be_b(ram_be_b),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i)
  );

  sram_bridge #(.DW(32), .AW(19), .LATENCY(L), .NATIVE_BE(1'b1)) u_dut_nb (
    .clk(clk), .rst_b(rst_b), .req_rd(nb_rd), .req_wr(nb_wr), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .rsp_rdata(nb_rdata), .rsp_ready(nb_ready),
    .ram_cs_b(nb_cs_b), .ram_oe_b(nb_oe_b), .ram_we_b(nb_we_b), .ram_be_b(nb_be_b),
    .ram_addr(nb_addr), .ram_dq_o(nb_dq_o), .ram_dq_oe(nb_dq_oe), .ram_dq_i(nb_dq_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return {i[7:0], 8'hC3, ~i[7:0], 8'h5A};
  endfunction

  // SRAM model (what the pins do) and golden memory (what the requests mean) are kept apart.
  logic [31:0] mem  [0:511];
  logic [31:0] gold [0:511];

  assign ram_dq_i = (!ram_cs_b && !ram_oe_b) ? mem[ram_addr[8:0]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (rst_b && !ram_cs_b && !ram_we_b && ram_dq_oe) begin
      for (int i = 0; i < 4; i++)
        if (!ram_be_b[i]) mem[ram_addr[8:0]][8*i +: 8] <= ram_dq_o[8*i +: 8];
    end
  end

  int oe_cnt = 0, we_cnt = 0, exp_oe = 0, exp_we = 0;
  always @(negedge clk) begin
    if (!ram_oe_b) oe_cnt++;
    if (!ram_we_b) we_cnt++;
  end

  typedef struct { logic [18:0] a; logic [31:0] d; } wexp_t;
  wexp_t wq[$];
  wexp_t we_e;
  logic  prev_we = 1'b1;

  always @(negedge clk) begin
    if (!ram_we_b && prev_we) begin
      chk("wr_pending", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        we_e = wq.pop_front();
        chk("wr_addr", ram_addr, we_e.a);
        chk("wr_data", ram_dq_o, we_e.d);
        chk("wr_be_b", ram_be_b, 4'h0);
        chk("wr_dq_oe", ram_dq_oe, 1);
      end
    end
    prev_we = ram_we_b;
  end

  int idle_from = 0;
  int last_rsp  = -100;

  task automatic do_txn(input bit rd, input bit wr, input logic [18:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int gap, output logic [31:0] rdat);
    int p, acc, lat, busy, exp_edge, got_edge;
    logic [31:0] nw, exp_rd;
    rdat = '0;
    exp_rd = '0;
    repeat (gap) begin @(posedge clk); #1; end
    p = cyc;
    acc = p + 1;
    if (idle_from + 1 > acc) acc = idle_from + 1;
    if (last_rsp + 2 > acc)  acc = last_rsp + 2;
    if (rd) begin
      lat = L + 1; busy = L + 1;
      exp_rd = gold[a[8:0]];
      exp_oe += L + 1;
    end else if (be == 4'h0) begin
      lat = 0; busy = 0;
    end else begin
      for (int i = 0; i < 4; i++) nw[8*i +: 8] = be[i] ? wd[8*i +: 8] : gold[a[8:0]][8*i +: 8];
      gold[a[8:0]] = nw;
      wq.push_back('{a: a, d: nw});
      exp_we += L + 1;
      if (be == 4'hF) busy = L + 1;
      else begin busy = 2 * L + 2; exp_oe += L + 1; end
      lat = POSTED ? 0 : busy;
    end
    exp_edge  = acc + lat;
    idle_from = acc + busy;
    last_rsp  = exp_edge;
    req_addr = a; req_be = be; req_wdata = wd; req_rd = rd; req_wr = wr;
    got_edge = -1;
    for (int n = 0; n < 64 && got_edge < 0; n++) begin
      @(negedge clk);
      if (rsp_ready) begin
        got_edge = cyc;
        rdat = rsp_rdata;
      end else if (cyc >= acc) begin
        // fields were latched at acceptance; scramble them to prove it
        req_addr = 19'($urandom); req_be = 4'($urandom); req_wdata = $urandom;
      end
    end
    chk("rsp_edge", got_edge, exp_edge);
    if (rd) chk("rd_data", rdat, exp_rd);
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic check_counts();
    repeat (10) @(posedge clk);
    #1;
    chk("oe_cycles", oe_cnt, exp_oe);
    chk("we_cycles", we_cnt, exp_we);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rdat;
    int noe, nwe, nedge, p;
    bit rd, wr;
    int r;
    logic [3:0] be;
    for (int i = 0; i < 512; i++) begin mem[i] = init_word(i); gold[i] = init_word(i); end

    repeat (2) @(negedge clk);
    chk("rst_cs_b", ram_cs_b, 1);
    chk("rst_oe_b", ram_oe_b, 1);
    chk("rst_we_b", ram_we_b, 1);
    chk("rst_be_b", ram_be_b, 4'hF);
    chk("rst_dq_oe", ram_dq_oe, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dq_o", ram_dq_o, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", rsp_ready, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    idle_from = cyc;

    do_txn(0, 1, 19'h10, 4'hF, 32'hDEAD_BEEF, 0, rdat);
    do_txn(1, 0, 19'h10, 4'h0, 32'h0, 0, rdat);
    chk("full_readback", rdat, 32'hDEAD_BEEF);
    do_txn(0, 1, 19'h40, 4'hF, 32'h1122_3344, 1, rdat);
    do_txn(0, 1, 19'h40, 4'b0100, 32'h00AA_0000, 0, rdat);
    do_txn(1, 0, 19'h40, 4'h0, 32'h0, 0, rdat);
    chk("rmw_readback", rdat, 32'h11AA_3344);
    do_txn(1, 1, 19'h20, 4'hF, 32'h1234_5678, 0, rdat);
    do_txn(0, 1, 19'h21, 4'h0, 32'hFFFF_FFFF, 0, rdat);
    do_txn(1, 0, 19'h20, 4'h0, 32'h0, 0, rdat);
    chk("rdwr_no_write", rdat, init_word(32));

    // Native byte-enable variant: partial write goes straight to WRITE with lane strobes.
    @(posedge clk); #1;
    p = cyc; noe = 0; nwe = 0; nedge = -1;
    req_addr = 19'h30; req_be = 4'b0100; req_wdata = 32'h00AA_0000; nb_wr = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!nb_oe_b) noe++;
      if (!nb_we_b) begin
        if (nwe == 0) begin
          chk("nb_be_b", nb_be_b, 4'b1011);
          chk("nb_lane2", nb_dq_o[23:16], 8'hAA);
          chk("nb_addr", nb_addr, 19'h30);
        end
        nwe++;
      end
      if (nb_ready && nedge < 0) begin nedge = cyc; nb_wr = 1'b0; end
    end
    chk("nb_rsp_edge", nedge, p + (POSTED ? 1 : 3));
    chk("nb_oe_cycles", noe, 0);
    chk("nb_we_cycles", nwe, 2);

    for (int t = 0; t < 150; t++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 4) || (r == 8);
      wr = (r >= 4);
      be = (r == 9) ? 4'h0 : 4'($urandom);
      do_txn(rd, wr, 19'h100 + 19'($urandom_range(0, 15)), be, $urandom,
             $urandom_range(0, 2), rdat);
    end
    check_counts();

    // Asynchronous reset in the middle of a write phase.
    p = cyc;
    wq.push_back('{a: 19'h7FFFF, d: 32'hCAFE_F00D});
    req_addr = 19'h7FFFF; req_be = 4'hF; req_wdata = 32'hCAFE_F00D; req_wr = 1'b1;
    for (int n = 0; n < 20 && ram_we_b; n++) @(negedge clk);
    chk("rst_mid_we_low", ram_we_b, 0);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_cs_b", ram_cs_b, 1);
    chk("arst_we_b", ram_we_b, 1);
    chk("arst_dq_oe", ram_dq_oe, 0);
    chk("arst_be_b", ram_be_b, 4'hF);
    chk("arst_addr", ram_addr, 0);
    chk("arst_ready", rsp_ready, 0);
    req_wr = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("arst_rdata", rsp_rdata, 0);
    oe_cnt = 0; we_cnt = 0; exp_oe = 0; exp_we = 0;
    idle_from = cyc; last_rsp = -100;

    do_txn(0, 1, 19'h50, 4'hF, 32'h0BAD_CAFE, 0, rdat);
    do_txn(1, 0, 19'h50, 4'h0, 32'h0, 0, rdat);
    chk("post_rst_readback", rdat, 32'h0BAD_CAFE);
    do_txn(0, 1, 19'h10, 4'b0011, 32'h0000_1357, 0, rdat);
    do_txn(1, 0, 19'h10, 4'h0, 32'h0, 0, rdat);
    chk("post_rst_rmw", rdat, 32'hDEAD_1357);
    check_counts();
    chk("wq_drained", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
